// File: rtl/mem_req_toggle.sv
// Per-channel toggle-handshake request generator for an SDRAM controller; one pending slot per channel.
// Latency: req toggles one clk_sys edge after a trigger when the channel is idle.
// Backpressure: toggle handshake; triggers while busy park in the pending slot, latest wins, ovf flags an overwrite.
module mem_req_toggle #(
    parameter int              NCH         = 6,
    parameter int              AW          = 24,
    parameter logic [NCH-1:0]  ADDR_RETRIG = {NCH{1'b1}},
    parameter bit              WE_PRIO     = 1'b1
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [NCH*AW-1:0]   ch_addr,
    input  logic [NCH-1:0]      ch_rd,
    input  logic [NCH-1:0]      ch_wr,
    input  logic [NCH-1:0]      ack,
    output logic [NCH-1:0]      req,
    output logic [NCH*AW-1:0]   req_addr,
    output logic [NCH-1:0]      req_we,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      ovf
);

    typedef enum logic [1:0] {IDLE, BUSY, PEND} state_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t          state, state_nxt;
        logic            rd_d, wr_d;
        logic [AW-1:0]   last_addr, addr;
        logic [AW-1:0]   pend_addr, pend_addr_nxt, out_addr, out_addr_nxt;
        logic            pend_we, pend_we_nxt, out_we, out_we_nxt;
        logic            req_q, req_nxt, ovf_q, ovf_nxt;
        logic            rd_trig, wr_trig, trig, trig_we, ack_match;

        assign addr      = ch_addr[i*AW +: AW];
        assign wr_trig   = ch_wr[i] & ~wr_d;
        assign rd_trig   = (ch_rd[i] & ~rd_d) |
                           (ch_rd[i] & ADDR_RETRIG[i] & (addr != last_addr));
        assign trig      = rd_trig | wr_trig;
        assign trig_we   = wr_trig & (~rd_trig | WE_PRIO);
        assign ack_match = (req_q == ack[i]);

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                state     <= IDLE;
                req_q     <= ack[i];
                out_addr  <= '0;
                out_we    <= 1'b0;
                pend_addr <= '0;
                pend_we   <= 1'b0;
                ovf_q     <= 1'b0;
                rd_d      <= 1'b0;
                wr_d      <= 1'b0;
                last_addr <= '1;
            end else begin
                state     <= state_nxt;
                req_q     <= req_nxt;
                out_addr  <= out_addr_nxt;
                out_we    <= out_we_nxt;
                pend_addr <= pend_addr_nxt;
                pend_we   <= pend_we_nxt;
                ovf_q     <= ovf_nxt;
                rd_d      <= ch_rd[i];
                wr_d      <= ch_wr[i];
                last_addr <= addr;
            end
        end

        always_comb begin
            state_nxt     = state;
            req_nxt       = req_q;
            out_addr_nxt  = out_addr;
            out_we_nxt    = out_we;
            pend_addr_nxt = pend_addr;
            pend_we_nxt   = pend_we;
            ovf_nxt       = ovf_q;
            case (state)
                IDLE: begin
                    // Tracking ack while idle swallows stray toggles of a request discarded by reset.
                    req_nxt = ack[i];
                    if (trig) begin
                        req_nxt      = ~ack[i];
                        out_addr_nxt = addr;
                        out_we_nxt   = trig_we;
                        state_nxt    = BUSY;
                    end
                end
                BUSY: begin
                    if (ack_match && trig) begin
                        req_nxt      = ~req_q;
                        out_addr_nxt = addr;
                        out_we_nxt   = trig_we;
                    end else if (ack_match) begin
                        state_nxt = IDLE;
                    end else if (trig) begin
                        pend_addr_nxt = addr;
                        pend_we_nxt   = trig_we;
                        state_nxt     = PEND;
                    end
                end
                PEND: begin
                    if (ack_match) begin
                        req_nxt      = ~req_q;
                        out_addr_nxt = pend_addr;
                        out_we_nxt   = pend_we;
                        state_nxt    = BUSY;
                        if (trig) begin
                            pend_addr_nxt = addr;
                            pend_we_nxt   = trig_we;
                            state_nxt     = PEND;
                        end
                    end else if (trig) begin
                        pend_addr_nxt = addr;
                        pend_we_nxt   = trig_we;
                        ovf_nxt       = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign req[i]                = req_q;
        assign req_addr[i*AW +: AW]  = out_addr;
        assign req_we[i]             = out_we;
        assign busy[i]               = req_q ^ ack[i];
        assign ovf[i]                = ovf_q;
    end

endmodule

// File: tb/tb_mem_req_toggle.sv
// Bench for mem_req_toggle: directed handshake scenarios plus a short pseudo-random phase,
// checked every cycle against a transaction-level model (one in-flight request + one pending slot per channel).
module tb_mem_req_toggle;
    localparam int             NCH    = 6;
    localparam int             AW     = 24;
    localparam logic [NCH-1:0] RETRIG = 6'b111101;
    localparam bit             WEP    = 1'b1;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_rd, ch_wr, ack;
    logic [NCH-1:0]    req, req_we, busy, ovf;
    logic [NCH*AW-1:0] req_addr;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    mem_req_toggle #(.NCH(NCH), .AW(AW), .ADDR_RETRIG(RETRIG), .WE_PRIO(WEP)) dut (
        .clk_sys(clk_sys), .reset(reset), .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr),
        .ack(ack), .req(req), .req_addr(req_addr), .req_we(req_we), .busy(busy), .ovf(ovf)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ra(input int i);
        return 32'(req_addr[i*AW +: AW]);
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] v);
        ch_addr[i*AW +: AW] = v;
    endtask

    task automatic cyc();
        @(negedge clk_sys);
        #1;
    endtask

    // Model: each channel owns at most one outstanding request and one waiting request.
    logic          m_req [NCH], m_we [NCH], m_ovf [NCH], m_out [NCH];
    logic          m_pv [NCH], m_pw [NCH], p_rd [NCH], p_wr [NCH];
    logic [AW-1:0] m_addr [NCH], m_pa [NCH], p_addr [NCH];

    always @(posedge clk_sys) begin
        for (int i = 0; i < NCH; i++) begin
            logic [AW-1:0] a;
            logic tw, tr, t, we, done;
            a = ch_addr[i*AW +: AW];
            if (reset) begin
                m_req[i] = ack[i]; m_addr[i] = '0; m_we[i] = 1'b0; m_ovf[i] = 1'b0;
                m_out[i] = 1'b0; m_pv[i] = 1'b0;
                p_rd[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '1;
            end else begin
                tw = ch_wr[i] && !p_wr[i];
                tr = ch_rd[i] && (!p_rd[i] || (RETRIG[i] && a != p_addr[i]));
                t  = tw || tr;
                we = tw && (!tr || WEP);
                done = !m_out[i] || (m_req[i] == ack[i]);
                if (done) begin
                    m_req[i] = ack[i];
                    m_out[i] = 1'b0;
                    if (m_pv[i]) begin
                        m_req[i] = ~ack[i]; m_addr[i] = m_pa[i]; m_we[i] = m_pw[i];
                        m_out[i] = 1'b1; m_pv[i] = 1'b0;
                        if (t) begin m_pv[i] = 1'b1; m_pa[i] = a; m_pw[i] = we; end
                    end else if (t) begin
                        m_req[i] = ~ack[i]; m_addr[i] = a; m_we[i] = we; m_out[i] = 1'b1;
                    end
                end else if (t) begin
                    if (m_pv[i]) m_ovf[i] = 1'b1;
                    m_pv[i] = 1'b1; m_pa[i] = a; m_pw[i] = we;
                end
                p_rd[i] = ch_rd[i]; p_wr[i] = ch_wr[i]; p_addr[i] = a;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            for (int i = 0; i < NCH; i++) begin
                chk($sformatf("model req[%0d]", i),      32'(req[i]),    32'(m_req[i]));
                chk($sformatf("model busy[%0d]", i),     32'(busy[i]),   32'(m_req[i] ^ ack[i]));
                chk($sformatf("model req_we[%0d]", i),   32'(req_we[i]), 32'(m_we[i]));
                chk($sformatf("model req_addr[%0d]", i), ra(i),          32'(m_addr[i]));
                chk($sformatf("model ovf[%0d]", i),      32'(ovf[i]),    32'(m_ovf[i]));
            end
        end
    end

    initial begin
        reset = 1'b1; ch_addr = '0; ch_rd = '0; ch_wr = '0; ack = 6'b000100;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("reset req", 32'(req), 32'h04);
        chk("reset busy", 32'(busy), 32'h0);
        reset = 1'b0;
        cyc();
        chk("post-reset req", 32'(req), 32'h04);
        chk("post-reset ovf", 32'(ovf), 32'h0);
        chk("post-reset req_addr0", ra(0), 32'h0);

        // Read rises on ch0.
        set_addr(0, 24'h000100); ch_rd[0] = 1'b1;
        cyc();
        chk("rd req0", 32'(req[0]), 32'h1);
        chk("rd addr0", ra(0), 32'h100);
        chk("rd we0", 32'(req_we[0]), 32'h0);
        chk("rd busy0", 32'(busy[0]), 32'h1);
        // Address change while busy parks in pending, ack promotes it.
        set_addr(0, 24'h000102);
        cyc();
        chk("pend hold req0", 32'(req[0]), 32'h1);
        chk("pend hold addr0", ra(0), 32'h100);
        ack[0] = 1'b1;
        cyc();
        chk("pend issue req0", 32'(req[0]), 32'h0);
        chk("pend issue addr0", ra(0), 32'h102);
        chk("pend issue ovf0", 32'(ovf[0]), 32'h0);
        ack[0] = 1'b0;
        cyc();
        chk("idle busy0", 32'(busy[0]), 32'h0);
        // Two retriggers while busy overwrite the pending slot.
        set_addr(0, 24'h0001F0); cyc();
        set_addr(0, 24'h000200); cyc();
        set_addr(0, 24'h000204); cyc();
        chk("ovf0 set", 32'(ovf[0]), 32'h1);
        chk("ovf addr0 stable", ra(0), 32'h1F0);
        ack[0] = 1'b1;
        cyc();
        chk("ovf latest addr0", ra(0), 32'h204);
        ack[0] = 1'b0; ch_rd[0] = 1'b0;
        cyc();

        // ch1: simultaneous rd/wr, write wins; no address retrigger.
        set_addr(1, 24'h000050); ch_rd[1] = 1'b1; ch_wr[1] = 1'b1;
        cyc();
        chk("prio req1", 32'(req[1]), 32'h1);
        chk("prio we1", 32'(req_we[1]), 32'h1);
        set_addr(1, 24'h000060);
        cyc();
        ack[1] = 1'b1;
        cyc();
        chk("noretrig busy1", 32'(busy[1]), 32'h0);
        set_addr(1, 24'h000070);
        cyc();
        chk("noretrig req1", 32'(req[1]), 32'h1);
        chk("noretrig addr1", ra(1), 32'h50);
        ch_rd[1] = 1'b0; ch_wr[1] = 1'b0;

        // ch2 came out of reset with ack=1.
        set_addr(2, 24'h000333); ch_wr[2] = 1'b1;
        cyc();
        chk("ack1 reset req2", 32'(req[2]), 32'h0);
        chk("ack1 reset we2", 32'(req_we[2]), 32'h1);
        ack[2] = 1'b0; ch_wr[2] = 1'b0;
        cyc();

        // ch3: ack and a new trigger land together.
        set_addr(3, 24'h000400); ch_rd[3] = 1'b1;
        cyc();
        ack[3] = 1'b1; set_addr(3, 24'h000404);
        cyc();
        chk("ack+trig req3", 32'(req[3]), 32'h0);
        chk("ack+trig addr3", ra(3), 32'h404);
        chk("ack+trig ovf3", 32'(ovf[3]), 32'h0);
        ack[3] = 1'b0; ch_rd[3] = 1'b0;
        cyc();

        // Reset in the middle of requests on ch4 (pending) and ch5 (in flight).
        set_addr(4, 24'h000010); ch_rd[4] = 1'b1;
        set_addr(5, 24'h000500); ch_rd[5] = 1'b1;
        cyc();
        set_addr(4, 24'h000011);
        cyc();
        ch_rd[5] = 1'b0; reset = 1'b1;
        cyc();
        chk("midreset req", 32'(req), 32'(ack));
        chk("midreset ovf", 32'(ovf), 32'h0);
        reset = 1'b0;
        cyc();
        chk("held strobe req4", 32'(req[4]), 32'h1);
        chk("held strobe addr4", ra(4), 32'h11);
        ack[5] = 1'b1;
        cyc();
        chk("stray ack req5", 32'(req[5]), 32'h1);
        chk("stray ack busy5", 32'(busy[5]), 32'h0);
        ch_rd[4] = 1'b0;

        // Pseudo-random phase: controller acks busy channels after random delays.
        for (int n = 0; n < 400; n++) begin
            ch_rd = NCH'($urandom);
            ch_wr = NCH'($urandom) & NCH'($urandom);
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 2) == 0) set_addr(i, AW'($urandom_range(0, 3)));
                if (req[i] != ack[i] && $urandom_range(0, 2) == 0) ack[i] = req[i];
            end
            cyc();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
